// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: op codes and FSM states.
package mips_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_INIT,
    S_DIV_ITER,
    S_DIV_FIX
  } md_state_e;

endpackage

// File: rtl/mips_divider_core.sv
// Iterative radix-2 restoring divider for unsigned WIDTH-bit operands.
// The start cycle loads the operands and performs iteration 0 in the same edge.
module mips_divider_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [WIDTH:0]   rem_q, srcRem, remStep;
  logic [WIDTH-1:0] quo_q, dvs_q, srcQuo, srcDvs, quoStep;
  logic [WIDTH+1:0] shifted, trial;
  logic [CW-1:0]    cnt_q;
  logic             run_q, valid_q, ge;

  always_comb begin
    srcRem  = start_i ? '0 : rem_q;
    srcQuo  = start_i ? dividend_i : quo_q;
    srcDvs  = start_i ? divisor_i : dvs_q;
    shifted = {srcRem, srcQuo[WIDTH-1]};
    trial   = shifted - {2'b00, srcDvs};
    ge      = ~trial[WIDTH+1];
    remStep = ge ? trial[WIDTH:0] : shifted[WIDTH:0];
    quoStep = {srcQuo[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (abort_i) begin
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (start_i) begin
      rem_q   <= remStep;
      quo_q   <= quoStep;
      dvs_q   <= divisor_i;
      cnt_q   <= CW'(1);
      run_q   <= 1'b1;
      valid_q <= 1'b0;
    end else if (run_q) begin
      rem_q   <= remStep;
      quo_q   <= quoStep;
      cnt_q   <= cnt_q + CW'(1);
      run_q   <= (cnt_q != LAST_ITER);
      valid_q <= (cnt_q == LAST_ITER);
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign last_o      = run_q && (cnt_q == LAST_ITER);
  assign valid_o     = valid_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q[WIDTH-1:0];

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS multiply/divide unit owning HI/LO: pipelined multiply, iterative divide,
// busy/done handshake for the hazard unit.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               MUL_STAGES  = 3,
  parameter logic [WIDTH-1:0] DIV_ZERO_LO = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] divA_q, divA_d, absA_q, absA_d, absB_q, absB_d;
  logic             negQ_q, negQ_d, negR_q, negR_d, divZero_q, divZero_d;
  logic             accept, kill, mulGo, mulSigned, divSigned;
  logic             divStart, divLast, divValid, mulOutVld;
  logic [WIDTH-1:0] divQuo, divRem;
  logic [WIDTH:0]   aExt, bExt;
  logic [2*WIDTH-1:0] mulIn, mulOut;

  assign accept    = (state_q == S_IDLE) && start_i && !flush_i;
  assign kill      = (state_q != S_IDLE) && flush_i;
  assign mulSigned = (op_i == MD_MULT);
  assign divSigned = (op_i == MD_DIV);
  assign mulGo     = accept && ((op_i == MD_MULT) || (op_i == MD_MULTU));
  assign mulIn     = {{WIDTH{mulSigned & a_i[WIDTH-1]}}, a_i} *
                     {{WIDTH{mulSigned & b_i[WIDTH-1]}}, b_i};
  // One extra bit so the magnitude of the most-negative operand is representable
  assign aExt      = {divSigned & a_i[WIDTH-1], a_i};
  assign bExt      = {divSigned & b_i[WIDTH-1], b_i};

  generate
    if (MUL_STAGES == 1) begin : g_mul_comb
      assign mulOut    = mulIn;
      assign mulOutVld = mulGo;
    end else begin : g_mul_pipe
      logic [2*WIDTH-1:0] prod_q [MUL_STAGES-1];
      logic [MUL_STAGES-2:0] vld_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst || kill) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= mulGo;
          for (int i = 1; i < MUL_STAGES - 1; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        prod_q[0] <= mulIn;
        for (int i = 1; i < MUL_STAGES - 1; i++) prod_q[i] <= prod_q[i-1];
      end

      assign mulOut    = prod_q[MUL_STAGES-2];
      assign mulOutVld = vld_q[MUL_STAGES-2];
    end
  endgenerate

  mips_divider_core #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (divStart),
    .abort_i    (kill),
    .dividend_i (absA_q),
    .divisor_i  (absB_q),
    .last_o     (divLast),
    .valid_o    (divValid),
    .quotient_o (divQuo),
    .remainder_o(divRem)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divA_d    = divA_q;
    absA_d    = absA_q;
    absB_d    = absB_q;
    negQ_d    = negQ_q;
    negR_d    = negR_q;
    divZero_d = divZero_q;
    divStart  = 1'b0;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (op_i)
              MD_MULT, MD_MULTU: state_d = (MUL_STAGES > 1) ? S_MUL : S_IDLE;
              MD_DIV, MD_DIVU: begin
                divA_d    = a_i;
                absA_d    = WIDTH'(aExt[WIDTH] ? -aExt : aExt);
                absB_d    = WIDTH'(bExt[WIDTH] ? -bExt : bExt);
                negQ_d    = aExt[WIDTH] ^ bExt[WIDTH];
                negR_d    = aExt[WIDTH];
                divZero_d = (b_i == '0);
                state_d   = S_DIV_INIT;
              end
              MD_MTHI: hi_d = a_i;
              MD_MTLO: lo_d = a_i;
              default: ;
            endcase
          end
        end
        S_MUL:      if (mulOutVld) state_d = S_IDLE;
        S_DIV_INIT: begin
          divStart = 1'b1;
          state_d  = S_DIV_ITER;
        end
        S_DIV_ITER: if (divLast) state_d = S_DIV_FIX;
        S_DIV_FIX: begin
          if (divValid) begin
            lo_d    = divZero_q ? DIV_ZERO_LO : (negQ_q ? -divQuo : divQuo);
            hi_d    = divZero_q ? divA_q : (negR_q ? -divRem : divRem);
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (mulOutVld) begin
        {hi_d, lo_d} = mulOut;
        done_d       = 1'b1;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divA_q    <= '0;
      absA_q    <= '0;
      absB_q    <= '0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divA_q    <= divA_d;
      absA_q    <= absA_d;
      absB_q    <= absB_d;
      negQ_q    <= negQ_d;
      negR_q    <= negR_d;
      divZero_q <= divZero_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit (WIDTH=32, MUL_STAGES=3).
module tb_mips_muldiv_unit;
  import mips_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             flush;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  int doneSeen;

  always #5 clk = ~clk;

  mips_muldiv_unit #(
    .WIDTH      (WIDTH),
    .MUL_STAGES (3),
    .DIV_ZERO_LO(32'hFFFF_FFFF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .flush_i(flush),
    .busy_o (busy),
    .done_o (done),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  // Advance to just after the next rising edge so outputs are stable
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive a one-cycle start; returns in cycle 1 of the operation
  task automatic applyStimulus(input logic [2:0] opIn, input logic [WIDTH-1:0] aIn,
                               input logic [WIDTH-1:0] bIn);
    start = 1'b1;
    op    = opIn;
    a     = aIn;
    b     = bIn;
    tick();
    start = 1'b0;
  endtask

  // Full-latency divide: busy through cycle 33, result with done in cycle 34
  task automatic runDiv(input string tag, input logic [2:0] opIn,
                        input logic [WIDTH-1:0] aIn, input logic [WIDTH-1:0] bIn,
                        input logic [WIDTH-1:0] expLo, input logic [WIDTH-1:0] expHi);
    applyStimulus(opIn, aIn, bIn);
    repeat (32) tick();
    checkOutput({tag, "_busy33"}, busy, 1);
    checkOutput({tag, "_done33"}, done, 0);
    tick();
    checkOutput({tag, "_done34"}, done, 1);
    checkOutput({tag, "_busy34"}, busy, 0);
    checkOutput({tag, "_lo"}, lo, expLo);
    checkOutput({tag, "_hi"}, hi, expHi);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    tick();
    tick();
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    rst = 1'b0;
    tick();

    $display("[TB] MULT -3 * 7");
    applyStimulus(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    checkOutput("mult_busy1", busy, 1);
    checkOutput("mult_done1", done, 0);
    tick();
    checkOutput("mult_busy2", busy, 1);
    tick();
    checkOutput("mult_done3", done, 1);
    checkOutput("mult_busy3", busy, 0);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFEB);
    tick();
    checkOutput("mult_done4", done, 0);

    $display("[TB] MULTU 0xFFFFFFFF * 2");
    applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    checkOutput("multu_busy1", busy, 1);
    tick();
    checkOutput("multu_busy2", busy, 1);
    tick();
    checkOutput("multu_done3", done, 1);
    checkOutput("multu_hi", hi, 32'h0000_0001);
    checkOutput("multu_lo", lo, 32'hFFFF_FFFE);

    $display("[TB] DIV -7 / 2 issued in the MULTU done cycle");
    applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div_busy1", busy, 1);
    repeat (4) tick();
    start = 1'b1; op = MD_MTHI; a = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    checkOutput("div_ignoredMthi", hi, 32'h0000_0001);
    repeat (27) tick();
    checkOutput("div_busy33", busy, 1);
    checkOutput("div_lo33", lo, 32'hFFFF_FFFE);
    tick();
    checkOutput("div_done34", done, 1);
    checkOutput("div_busy34", busy, 0);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);

    runDiv("divu100by7", MD_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
    runDiv("divuByZero", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

    $display("[TB] DIVU flushed at cycle 10");
    applyStimulus(MD_DIVU, 32'd1000, 32'd3);
    repeat (3) tick();
    start = 1'b1; op = MD_MTLO; a = 32'h0000_AAAA;
    tick();
    start = 1'b0;
    checkOutput("flush_ignoredMtlo", lo, 32'hFFFF_FFFF);
    checkOutput("flush_busy5", busy, 1);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_busy11", busy, 0);
    checkOutput("flush_done11", done, 0);
    doneSeen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) doneSeen++;
      tick();
    end
    checkOutput("flush_noDone", doneSeen, 0);
    checkOutput("flush_hi", hi, 32'd5);
    checkOutput("flush_lo", lo, 32'hFFFF_FFFF);

    flush = 1'b1;
    applyStimulus(MD_MTHI, 32'd1, 32'd0);
    flush = 1'b0;
    checkOutput("flushStart_hi", hi, 32'd5);
    checkOutput("flushStart_busy", busy, 0);

    runDiv("divOverflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    runDiv("div7byNeg2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    runDiv("divNegByZero", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

    $display("[TB] MTHI / MTLO / reserved op");
    applyStimulus(MD_MTHI, 32'h1234_5678, 32'd0);
    checkOutput("mthi_hi", hi, 32'h1234_5678);
    checkOutput("mthi_done", done, 0);
    checkOutput("mthi_busy", busy, 0);
    applyStimulus(MD_MTLO, 32'h9ABC_DEF0, 32'd0);
    checkOutput("mtlo_lo", lo, 32'h9ABC_DEF0);
    checkOutput("mtlo_hi", hi, 32'h1234_5678);
    checkOutput("mtlo_done", done, 0);
    applyStimulus(3'd6, 32'h5555_5555, 32'd3);
    checkOutput("rsvd_busy", busy, 0);
    tick();
    tick();
    checkOutput("rsvd_done", done, 0);
    checkOutput("rsvd_hi", hi, 32'h1234_5678);
    checkOutput("rsvd_lo", lo, 32'h9ABC_DEF0);

    $display("[TB] MULT flushed in cycle 1");
    applyStimulus(MD_MULT, 32'd2, 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("mulFlush_busy2", busy, 0);
    tick();
    checkOutput("mulFlush_done3", done, 0);
    checkOutput("mulFlush_hi", hi, 32'h1234_5678);
    checkOutput("mulFlush_lo", lo, 32'h9ABC_DEF0);

    $display("[TB] flush in the MULT done cycle");
    applyStimulus(MD_MULT, 32'd2, 32'd3);
    tick();
    tick();
    checkOutput("doneFlush_done3", done, 1);
    checkOutput("doneFlush_lo3", lo, 32'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("doneFlush_hi4", hi, 32'd0);
    checkOutput("doneFlush_lo4", lo, 32'd6);
    checkOutput("doneFlush_busy4", busy, 0);

    $display("[TB] reset during MULTU");
    applyStimulus(MD_MULTU, 32'd4, 32'd5);
    checkOutput("rstMid_busy1", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstMid_busy", busy, 0);
    checkOutput("rstMid_lo", lo, 0);
    checkOutput("rstMid_hi", hi, 0);
    tick();
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) doneSeen++;
    end
    checkOutput("rstMid_noDone", doneSeen, 0);
    checkOutput("rstMid_loAfter", lo, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised multiply/divide unit holding the architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the ALU in the EX stage.
- Multiply is a fixed-latency pipeline; divide is an iterative radix-2 restoring divider.
- Exposes a busy/done handshake; the hazard unit turns busy into StallF/StallD/FlushE for MFHI/MFLO and back-to-back mult/div ops.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (even, ≥8).
- MUL_STAGES, 3, multiply latency in cycles (1..4), start to result.
- DIV_ZERO_LO, all-ones, LO value written on divide by zero.

Ports:
- clk  in  1  core clock (clk_div1 domain at top level).
- rst  in  1  asynchronous active-high reset.
- start  in  1  issue strobe, one cycle, sampled with op/a/b.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op).
- a  in  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO data).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  abort the in-flight mult/div; HI/LO keep prior values.
- busy  out  1  registered; unit occupied; new start ignored.
- done  out  1  one-cycle pulse; HI/LO hold the new result this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst=1):
  - hi=0, lo=0, busy=0, done=0.
  - FSM to IDLE; multiply pipe valid bits cleared.
  - Takes effect immediately, including mid-operation. The aborted op never writes HI/LO.
- FSM states: IDLE, MUL, DIV_INIT, DIV_ITER, DIV_FIX.
- Cycle numbering: start sampled at edge 0; outputs below are as observed in cycle n after edge n.
- MTHI/MTLO:
  - Accepted in IDLE only.
  - hi (or lo) = a in cycle 1.
  - No busy; no done pulse.
- MULT/MULTU:
  - 2·WIDTH product.
  - Signed: both operands sign-extended. Unsigned: zero-extended.
  - busy=1 in cycles 1..MUL_STAGES-1.
  - In cycle MUL_STAGES: done=1, busy=0, {hi,lo}=product.
  - MUL_STAGES=1: busy never rises; done in cycle 1.
- DIV/DIVU, total latency WIDTH+2:
  - DIV_INIT (1 cycle): latch |a|, |b| (signed) or raw values (unsigned); record quotient and remainder signs.
  - DIV_ITER (WIDTH cycles): shift-subtract, iteration counter runs 0..WIDTH-1.
  - DIV_FIX (1 cycle): negate quotient if signs differ; give remainder the sign of the dividend (truncation toward zero).
  - busy=1 in cycles 1..WIDTH+1.
  - In cycle WIDTH+2: done=1, busy=0, lo=quotient, hi=remainder.
  - Divisor 0: full latency still taken; lo=DIV_ZERO_LO, hi=a.
  - Signed overflow (most-negative / -1): lo=most-negative, hi=0, no trap.
- Handshake:
  - start while busy=1 is ignored, with no side effect.
  - start in the same cycle as done is accepted, since busy=0.
  - Reserved op: no-op.
- flush:
  - Any cycle with busy=1 returns the FSM to IDLE and clears the multiply pipe; busy=0 next cycle; no done; HI/LO unchanged.
  - flush with start in the same cycle: flush wins and start is dropped.
  - flush in the done cycle: no effect, result stands.
- Width rules:
  - Internal product register is 2·WIDTH.
  - Divider remainder register is WIDTH+1 bits.
  - Absolute values are computed in WIDTH+1 bits so the most-negative value is legal.

Decomposition:
- Shared package (mips_pkg) holds the op encodings (MD_MULT..MD_MTLO) and the FSM state typedef.
- One natural sub-module, mips_divider_core: the iterative unsigned WIDTH-bit divider with start/abort/valid.
- Sign handling and the multiply pipe stay in the parent.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 → done at cycle 3; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE; busy high cycles 1-2.
- DIV a=0xFFFFFFF9 (-7), b=2 → done at cycle 34; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 → lo=14, hi=2. Then DIVU b=0, a=5 → lo=0xFFFFFFFF, hi=5.
- DIVU started, flush at cycle 10 → busy=0 in cycle 11, no done; hi/lo keep previous values. A second start while busy is ignored.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 → hi/lo updated in cycle 1, done stays 0. Assert rst mid-MULT → hi=lo=0, busy=0 immediately.
